// File: rtl/la_stream_ftdi_pkg.sv
// Shared types and FTDI fast-serial frame constants for the logic-analyser streamer.
package la_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE
    } la_state_t;

    localparam int       FRAME_BITS = 10;
    localparam int       IDLE_BITS  = 1;
    localparam logic     START_BIT  = 1'b0;

    // Masked equality; channels outside the mask never block the trigger.
    function automatic logic trig_hit(input logic [31:0] sample,
                                      input logic [31:0] mask,
                                      input logic [31:0] value);
        return ((sample ^ value) & mask) == 32'd0;
    endfunction

endpackage

// File: rtl/la_stream_ftdi_if.sv
// FTDI synchronous fast-serial link: data out, forwarded clock, clear-to-send in.
interface la_stream_ftdi_if;

    logic fsdi;
    logic fsclk;
    logic fscts;

    modport master (output fsdi, output fsclk, input fscts);
    modport slave  (input fsdi, input fsclk, output fscts);

endinterface

// File: rtl/la_stream_ftdi_tx.sv
// FTDI fast-serial byte transmitter: start bit, 8 data bits LSB first, destination bit, idle gap.
module ftdi_fs_tx
    import la_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       dest_b,
    input  logic       fscts,
    output logic       fsdi
);

    localparam int                CNT_W    = $clog2(FRAME_BITS + IDLE_BITS + 1);
    localparam logic [CNT_W-1:0]  DATA_END = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_BITS + IDLE_BITS - 1);

    logic                   busy;
    logic [CNT_W-1:0]       bit_cnt;
    logic [FRAME_BITS-2:0]  shift_q;

    // CTS is only looked at between frames; a started frame always runs to completion.
    assign tx_ready = !busy && fscts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            bit_cnt <= '0;
            fsdi    <= 1'b1;
        end else if (!busy) begin
            if (tx_valid && fscts) begin
                fsdi    <= START_BIT;
                busy    <= 1'b1;
                bit_cnt <= CNT_W'(1);
            end
        end else begin
            fsdi    <= (bit_cnt < DATA_END) ? shift_q[0] : 1'b1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
                busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!busy && tx_valid && fscts) begin
            shift_q <= {dest_b, tx_data};
        end else if (busy) begin
            shift_q <= shift_q >> 1;
        end
    end

endmodule

// File: rtl/la_stream_ftdi.sv
// Logic-analyser capture engine: synchronise, divide, trigger, buffer, and stream samples over FTDI fast serial.
module la_stream_ftdi
    import la_pkg::*;
#(
    parameter int CHANNELS   = 8,
    parameter int FIFO_DEPTH = 64,
    parameter int DIV_W      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    la_stream_ftdi_if.master    ftdi,
    input  logic [CHANNELS-1:0] logic_in,
    input  logic                arm,
    input  logic                trig_en,
    input  logic [CHANNELS-1:0] trig_mask,
    input  logic [CHANNELS-1:0] trig_value,
    input  logic [DIV_W-1:0]    div,
    input  logic                dest_b,
    output logic                triggered,
    output logic                overflow
);

    localparam int NB   = CHANNELS / 8;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int BL_W = 3;

    la_state_t              state;
    logic [CHANNELS-1:0]    sync_p0;
    logic [CHANNELS-1:0]    sync_p1;
    logic [DIV_W-1:0]       div_cnt;
    logic                   strobe;
    logic                   hit;
    logic                   wr_req;
    logic                   wr_ok;
    logic                   pop;
    logic                   flush;

    logic [CHANNELS-1:0]    mem [FIFO_DEPTH];
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic                   full;
    logic                   empty;
    logic [CHANNELS-1:0]    head;

    logic [CHANNELS-1:0]    word_q;
    logic                   word_vld;
    logic [BL_W-1:0]        bytes_left;
    logic [7:0]             tx_data;
    logic                   tx_valid;
    logic                   tx_ready;

    assign ftdi.fsclk = clk;

    // Stage p0/p1: two-flop synchroniser on the asynchronous probes.
    always_ff @(posedge clk) begin
        sync_p0 <= logic_in;
        sync_p1 <= sync_p0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (state == IDLE || div_cnt == div) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign strobe = arm && (state != IDLE) && (div_cnt == div);
    assign hit    = trig_hit(32'(sync_p1), 32'(trig_mask), 32'(trig_value));
    assign wr_req = strobe && ((state == CAPTURE) || (state == ARMED && hit));
    assign flush  = !arm;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign pop   = tx_valid && tx_ready && !word_vld;
    assign wr_ok = wr_req && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= sync_p1;
        end
    end

    // Byte 0 goes straight from the FIFO head; the remaining bytes wait in word_q.
    assign tx_valid = arm && (word_vld || !empty);
    assign tx_data  = word_vld ? word_q[7:0] : head[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_vld   <= 1'b0;
            bytes_left <= '0;
        end else if (flush) begin
            word_vld   <= 1'b0;
        end else if (tx_valid && tx_ready) begin
            if (!word_vld) begin
                word_vld   <= (NB > 1);
                bytes_left <= BL_W'(NB - 1);
            end else begin
                bytes_left <= bytes_left - 1'b1;
                if (bytes_left == BL_W'(1)) begin
                    word_vld <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tx_valid && tx_ready) begin
            word_q <= (word_vld ? word_q : head) >> 8;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            triggered <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wr_req && full && !pop) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (arm) begin
                        overflow  <= 1'b0;
                        state     <= trig_en ? ARMED : CAPTURE;
                        triggered <= !trig_en;
                    end
                end
                ARMED: begin
                    if (!arm) begin
                        state <= IDLE;
                    end else if (strobe && hit) begin
                        state     <= CAPTURE;
                        triggered <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (!arm) begin
                        state     <= IDLE;
                        triggered <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    triggered <= 1'b0;
                end
            endcase
        end
    end

    ftdi_fs_tx u_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .dest_b   (dest_b),
        .fscts    (ftdi.fscts),
        .fsdi     (ftdi.fsdi)
    );

endmodule

// File: tb/tb_la_stream_ftdi.sv
// Directed bench for la_stream_ftdi: an 8-channel and a 16-channel instance share the control inputs.
module tb_la_stream_ftdi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm8, arm16, trig_en, dest_b, fscts;
    logic [7:0]  logic_in8;
    logic [15:0] logic_in16, trig_mask, trig_value, div;
    logic        triggered8, overflow8, triggered16, overflow16;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    la_stream_ftdi_if if8 ();
    la_stream_ftdi_if if16 ();
    assign if8.fscts  = fscts;
    assign if16.fscts = fscts;

    la_stream_ftdi #(.CHANNELS(8), .FIFO_DEPTH(64), .DIV_W(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .ftdi(if8), .logic_in(logic_in8), .arm(arm8),
        .trig_en(trig_en), .trig_mask(trig_mask[7:0]), .trig_value(trig_value[7:0]),
        .div(div), .dest_b(dest_b), .triggered(triggered8), .overflow(overflow8)
    );

    la_stream_ftdi #(.CHANNELS(16), .FIFO_DEPTH(64), .DIV_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .ftdi(if16), .logic_in(logic_in16), .arm(arm16),
        .trig_en(trig_en), .trig_mask(trig_mask), .trig_value(trig_value),
        .div(div), .dest_b(dest_b), .triggered(triggered16), .overflow(overflow16)
    );

    function automatic logic line(input int w);
        return (w != 0) ? if16.fsdi : if8.fsdi;
    endfunction

    // Waits up to timeout cycles for a start bit, then decodes 8 data bits and the dest bit.
    task automatic rx_byte(input int w, input int timeout, input int act_bit, input int act,
                           output logic [7:0] b, output logic d, output logic ok, output int t0);
        ok = 1'b0; b = '0; d = 1'b0; t0 = 0;
        for (int i = 0; i < timeout; i++) begin
            @(negedge clk);
            if (line(w) == 1'b0) begin
                ok = 1'b1;
                t0 = cyc;
                break;
            end
        end
        if (ok) begin
            for (int i = 0; i < 9; i++) begin
                @(negedge clk);
                if (i < 8) b[i] = line(w);
                else       d    = line(w);
                if (i == act_bit) begin
                    if (act == 1)      fscts = 1'b0;
                    else if (act == 2) arm8  = 1'b0;
                end
            end
        end
    endtask

    task automatic idle_all();
        arm8  = 1'b0;
        arm16 = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (if8.fsdi !== 1'b1) begin n_fail++; $display("FAIL reset_fsdi8: got %b expected 1", if8.fsdi); end
        n_tests++; if (if16.fsdi !== 1'b1) begin n_fail++; $display("FAIL reset_fsdi16: got %b expected 1", if16.fsdi); end
        n_tests++; if (triggered8 !== 1'b0) begin n_fail++; $display("FAIL reset_triggered: got %b expected 0", triggered8); end
        n_tests++; if (overflow8 !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow8); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_free_run();
        logic [7:0] b; logic d, ok; int t1, t2;
        trig_en = 1'b0; div = 16'd0; dest_b = 1'b1; fscts = 1'b1; logic_in8 = 8'hA5;
        repeat (4) @(negedge clk);
        arm8 = 1'b1;
        rx_byte(0, 50, -1, 0, b, d, ok, t1);
        n_tests++; if (b !== 8'hA5) begin n_fail++; $display("FAIL freerun_byte1: got %h expected a5", b); end
        n_tests++; if (d !== 1'b1) begin n_fail++; $display("FAIL freerun_dest: got %b expected 1", d); end
        @(negedge clk);
        n_tests++; if (if8.fsdi !== 1'b1) begin n_fail++; $display("FAIL freerun_idle_bit: got %b expected 1", if8.fsdi); end
        rx_byte(0, 50, -1, 0, b, d, ok, t2);
        n_tests++; if (b !== 8'hA5) begin n_fail++; $display("FAIL freerun_byte2: got %h expected a5", b); end
        n_tests++; if (t2 - t1 != 11) begin n_fail++; $display("FAIL freerun_period: got %0d expected 11", t2 - t1); end
        idle_all();
    endtask

    task automatic test_multibyte();
        logic [7:0] ba, bb, bc; logic d, oka, okb, okc; int ta, tb, tc;
        logic_in16 = 16'h1234; div = 16'd99; fscts = 1'b1;
        repeat (4) @(negedge clk);
        arm16 = 1'b1;
        rx_byte(1, 300, -1, 0, ba, d, oka, ta);
        rx_byte(1, 50, -1, 0, bb, d, okb, tb);
        rx_byte(1, 300, -1, 0, bc, d, okc, tc);
        n_tests++; if (ba !== 8'h34) begin n_fail++; $display("FAIL multi_lsb: got %h expected 34", ba); end
        n_tests++; if (bb !== 8'h12) begin n_fail++; $display("FAIL multi_msb: got %h expected 12", bb); end
        n_tests++; if (tb - ta != 11) begin n_fail++; $display("FAIL multi_byte_gap: got %0d expected 11", tb - ta); end
        n_tests++; if (bc !== 8'h34) begin n_fail++; $display("FAIL multi_next_lsb: got %h expected 34", bc); end
        n_tests++; if (tc - ta != 100) begin n_fail++; $display("FAIL multi_sample_period: got %0d expected 100", tc - ta); end
        n_tests++; if (overflow16 !== 1'b0) begin n_fail++; $display("FAIL multi_overflow: got %b expected 0", overflow16); end
        idle_all();
        div = 16'd0;
    endtask

    task automatic test_trigger();
        logic [7:0] b; logic d, ok; int t;
        trig_en = 1'b1; trig_mask = 16'h0001; trig_value = 16'h0001; div = 16'd0;
        fscts = 1'b1; logic_in8 = 8'h80;
        repeat (4) @(negedge clk);
        arm8 = 1'b1;
        rx_byte(0, 500, -1, 0, b, d, ok, t);
        n_tests++; if (ok !== 1'b0) begin n_fail++; $display("FAIL trig_early_frame: got %h expected none", b); end
        n_tests++; if (triggered8 !== 1'b0) begin n_fail++; $display("FAIL trig_armed: got %b expected 0", triggered8); end
        logic_in8 = 8'h81;
        repeat (2) @(negedge clk);
        n_tests++; if (triggered8 !== 1'b0) begin n_fail++; $display("FAIL trig_sync_latency: got %b expected 0", triggered8); end
        @(negedge clk);
        n_tests++; if (triggered8 !== 1'b1) begin n_fail++; $display("FAIL trig_assert: got %b expected 1", triggered8); end
        rx_byte(0, 20, -1, 0, b, d, ok, t);
        n_tests++; if (b !== 8'h81) begin n_fail++; $display("FAIL trig_first_byte: got %h expected 81", b); end
        idle_all();
        trig_en = 1'b0; trig_mask = '0; trig_value = '0;
    endtask

    task automatic test_overflow();
        logic [7:0] b; logic d, ok; int t, nframes, ngood;
        fscts = 1'b0; div = 16'd0; trig_en = 1'b0; logic_in8 = 8'h3C;
        repeat (4) @(negedge clk);
        arm8 = 1'b1;
        repeat (65) @(negedge clk);
        n_tests++; if (overflow8 !== 1'b0) begin n_fail++; $display("FAIL ovf_at_64: got %b expected 0", overflow8); end
        @(negedge clk);
        n_tests++; if (overflow8 !== 1'b1) begin n_fail++; $display("FAIL ovf_at_65: got %b expected 1", overflow8); end
        repeat (10) @(negedge clk);
        n_tests++; if (overflow8 !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow8); end
        div = 16'hFFFF; fscts = 1'b1;
        nframes = 0; ngood = 0;
        for (int i = 0; i < 64; i++) begin
            rx_byte(0, 30, -1, 0, b, d, ok, t);
            if (ok) nframes++;
            if (b == 8'h3C) ngood++;
        end
        n_tests++; if (nframes != 64) begin n_fail++; $display("FAIL ovf_drain_count: got %0d expected 64", nframes); end
        n_tests++; if (ngood != 64) begin n_fail++; $display("FAIL ovf_drain_data: got %0d expected 64", ngood); end
        rx_byte(0, 50, -1, 0, b, d, ok, t);
        n_tests++; if (ok !== 1'b0) begin n_fail++; $display("FAIL ovf_extra_frame: got %h expected none", b); end
        arm8 = 1'b0;
        @(negedge clk);
        arm8 = 1'b1;
        @(negedge clk);
        n_tests++; if (overflow8 !== 1'b0) begin n_fail++; $display("FAIL ovf_rearm_clear: got %b expected 0", overflow8); end
        idle_all();
        div = 16'd0;
    endtask

    task automatic test_cts_mid_frame();
        logic [7:0] b; logic d, ok; int t;
        logic_in8 = 8'h5A; fscts = 1'b1; div = 16'd0;
        repeat (4) @(negedge clk);
        arm8 = 1'b1;
        rx_byte(0, 50, 3, 1, b, d, ok, t);
        n_tests++; if (b !== 8'h5A) begin n_fail++; $display("FAIL cts_frame_completes: got %h expected 5a", b); end
        rx_byte(0, 40, -1, 0, b, d, ok, t);
        n_tests++; if (ok !== 1'b0) begin n_fail++; $display("FAIL cts_held_off: got %h expected none", b); end
        fscts = 1'b1;
        rx_byte(0, 20, -1, 0, b, d, ok, t);
        n_tests++; if (b !== 8'h5A) begin n_fail++; $display("FAIL cts_resume: got %h expected 5a", b); end
        idle_all();
    endtask

    task automatic test_disarm();
        logic [7:0] b; logic d, ok; int t;
        logic_in8 = 8'h96; fscts = 1'b1; div = 16'd0;
        repeat (4) @(negedge clk);
        arm8 = 1'b1;
        rx_byte(0, 50, 3, 2, b, d, ok, t);
        n_tests++; if (b !== 8'h96) begin n_fail++; $display("FAIL disarm_frame_completes: got %h expected 96", b); end
        rx_byte(0, 40, -1, 0, b, d, ok, t);
        n_tests++; if (ok !== 1'b0) begin n_fail++; $display("FAIL disarm_no_frame: got %h expected none", b); end
        n_tests++; if (if8.fsdi !== 1'b1) begin n_fail++; $display("FAIL disarm_idle: got %b expected 1", if8.fsdi); end
        logic_in8 = 8'h11;
        repeat (4) @(negedge clk);
        arm8 = 1'b1;
        rx_byte(0, 50, -1, 0, b, d, ok, t);
        n_tests++; if (b !== 8'h11) begin n_fail++; $display("FAIL disarm_fifo_flushed: got %h expected 11", b); end
        idle_all();
    endtask

    task automatic test_reset_mid_frame();
        logic found;
        logic_in8 = 8'h5A; fscts = 1'b1; div = 16'd0;
        repeat (4) @(negedge clk);
        arm8 = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (if8.fsdi == 1'b0) begin found = 1'b1; break; end
        end
        n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL rstmid_start: got %b expected 1", found); end
        n_tests++; if (triggered8 !== 1'b1) begin n_fail++; $display("FAIL rstmid_capture: got %b expected 1", triggered8); end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++; if (if8.fsdi !== 1'b1) begin n_fail++; $display("FAIL rstmid_fsdi: got %b expected 1", if8.fsdi); end
        n_tests++; if (triggered8 !== 1'b0) begin n_fail++; $display("FAIL rstmid_triggered: got %b expected 0", triggered8); end
        @(negedge clk);
        arm8 = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; arm8 = 1'b0; arm16 = 1'b0; trig_en = 1'b0; dest_b = 1'b1; fscts = 1'b0;
        logic_in8 = '0; logic_in16 = '0; trig_mask = '0; trig_value = '0; div = '0;
        test_reset();
        test_free_run();
        test_multibyte();
        test_trigger();
        test_overflow();
        test_cts_mid_frame();
        test_disarm();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
